sdrc_req_arb: RTL

- Multi-port front end that shares the single SDRAM core request port (req/req_ack) among NREQ application requesters.
- Arbitrates round-robin, latches the winner's request fields and presents them to the request generator.
- Returns the core's acknowledge to the granted port.
- Sits between the application/bus bridges and the SDRAM core top.

---
 rtl/sdrc_req_arb_pkg.sv | 9 +
 rtl/sdrc_rr_pick.sv | 28 ++
 rtl/sdrc_req_arb.sv | 99 +++++++++
 3 files changed

// File: rtl/sdrc_req_arb_pkg.sv
// sdrc_req_arb_pkg: shared request ID width and arbiter state encodings
package sdrc_req_arb_pkg;
  localparam int SDR_REQ_ID_W = 4;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_HOLD = 2'b10
  } arb_state_t;
endpackage

// File: rtl/sdrc_rr_pick.sv
// sdrc_rr_pick: first asserted req at or above rr_ptr (mod NREQ) as one-hot grant and binary idx
module sdrc_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [IW:0]   s;
  logic [IW-1:0] p;
  always_comb begin
    grant = '0;
    idx = '0;
    s = '0;
    p = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      s = {1'b0, rr_ptr} + (IW+1)'(i);
      p = IW'(s >= (IW+1)'(NREQ) ? s - (IW+1)'(NREQ) : s);
      if (req[p]) begin
        grant = '0;
        grant[p] = 1'b1;
        idx = p;
      end
    end
  end
endmodule

// File: rtl/sdrc_req_arb.sv
// sdrc_req_arb: round-robin share of the SDRAM core req/req_ack port among NREQ requesters (SDRC_ARB_HIPRI_EN: port 0 absolute priority)
module sdrc_req_arb #(
  parameter int NREQ         = 4,
  parameter int APP_AW       = 30,
  parameter int APP_RW       = 9,
  parameter int SDR_REQ_ID_W = sdrc_req_arb_pkg::SDR_REQ_ID_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NREQ-1:0]              m_req,
  input  logic [NREQ*(APP_AW+1)-1:0]   m_addr,
  input  logic [NREQ*(APP_AW-1)-1:0]   m_addr_mask,
  input  logic [NREQ*APP_RW-1:0]       m_len,
  input  logic [NREQ-1:0]              m_wr_n,
  input  logic [NREQ-1:0]              m_wrap,
  output logic [NREQ-1:0]              m_ack,
  output logic                         req,
  output logic [SDR_REQ_ID_W-1:0]      req_id,
  output logic [APP_AW:0]              req_addr,
  output logic [APP_AW-2:0]            req_addr_mask,
  output logic [APP_RW-1:0]            req_len,
  output logic                         req_wr_n,
  output logic                         req_wrap,
  input  logic                         req_ack,
  input  logic                         sdr_core_busy_n,
  output logic [NREQ-1:0]              arb_grant
);
  import sdrc_req_arb_pkg::*;
  localparam int IW  = $clog2(NREQ);
  localparam int AW1 = APP_AW + 1;
  localparam int MW  = APP_AW - 1;
  arb_state_t      state;
  logic [IW-1:0]   rr_ptr, gidx, pick_idx, win_idx, nxt_ptr;
  logic [NREQ-1:0] pick_req, pick_grant, win_grant;
  logic [AW1-1:0]    addr_a [NREQ];
  logic [MW-1:0]     mask_a [NREQ];
  logic [APP_RW-1:0] len_a  [NREQ];
  genvar k;
  for (k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_a[k] = m_addr[k*AW1 +: AW1];
    assign mask_a[k] = m_addr_mask[k*MW +: MW];
    assign len_a[k]  = m_len[k*APP_RW +: APP_RW];
  end
  sdrc_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (pick_req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );
`ifdef SDRC_ARB_HIPRI_EN
  // port 0 is kept out of the rotation and overrides it; its grants leave rr_ptr alone
  assign pick_req  = {m_req[NREQ-1:1], 1'b0};
  assign win_idx   = m_req[0] ? '0 : pick_idx;
  assign win_grant = m_req[0] ? NREQ'(1) : pick_grant;
  assign nxt_ptr   = (gidx == '0) ? rr_ptr : (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
`else
  assign pick_req  = m_req;
  assign win_idx   = pick_idx;
  assign win_grant = pick_grant;
  assign nxt_ptr   = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
`endif
  assign req_id = SDR_REQ_ID_W'(gidx);
  assign m_ack  = arb_grant & {NREQ{req_ack && state == ARB_REQ}};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ARB_IDLE;
      rr_ptr        <= '0;
      gidx          <= '0;
      req           <= 1'b0;
      req_addr      <= '0;
      req_addr_mask <= '0;
      req_len       <= '0;
      req_wr_n      <= 1'b0;
      req_wrap      <= 1'b0;
      arb_grant     <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (|m_req && sdr_core_busy_n) begin
          state         <= ARB_REQ;
          req           <= 1'b1;
          arb_grant     <= win_grant;
          gidx          <= win_idx;
          req_addr      <= addr_a[win_idx];
          req_addr_mask <= mask_a[win_idx];
          req_len       <= len_a[win_idx];
          req_wr_n      <= m_wr_n[win_idx];
          req_wrap      <= m_wrap[win_idx];
        end
        ARB_REQ: if (req_ack) begin
          state     <= ARB_HOLD;
          req       <= 1'b0;
          arb_grant <= '0;
          rr_ptr    <= nxt_ptr;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule
